stabilizer_row_reader: RTL and testbench



---
 rtl/stabilizer_row_reader_pkg.sv | 16 +
 rtl/stabilizer_row_reader.sv | 148 ++++++++++++++
 tb/tb_stabilizer_row_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stabilizer_row_reader_pkg.sv
// Shared FSM states and shift codes used by the row reader and the row-shift array.
package stabilizer_row_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] SHIFT_DOWN  = 2'd0;
  localparam logic [1:0] ROTATE_DOWN = 2'd1;
  localparam logic [1:0] ROTATE_LEFT = 2'd2;

endpackage

// File: rtl/stabilizer_row_reader.sv
// Streams the stabilizer matrix out of the row-shift array one bottom row per transfer,
// rotating the array down so that a complete unload (normal or aborted) restores its order.
module stabilizer_row_reader
  import stabilizer_row_reader_pkg::*;
#(
  parameter int num_qubit = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     ld_reg,
  output logic [1:0]               shift_rotate_array,
  input  logic [2*num_qubit-1:0]   arr_literals,
  input  logic                     arr_phase,
  output logic [2*num_qubit-1:0]   row_literals,
  output logic                     row_phase,
  output logic [31:0]              row_index,
  output logic                     row_valid,
  input  logic                     row_ready
);

  localparam int               CNT_W    = $clog2(num_qubit) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(num_qubit - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       rot_cnt_q, rot_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   row_valid_q, row_valid_d;
  logic [2*num_qubit-1:0] row_literals_q, row_literals_d;
  logic                   row_phase_q, row_phase_d;
  logic [31:0]            row_index_q, row_index_d;
  logic                   rotate;

  always_comb begin
    state_d        = state_q;
    rot_cnt_d      = rot_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    row_valid_d    = row_valid_q;
    row_literals_d = row_literals_q;
    row_phase_d    = row_phase_q;
    row_index_d    = row_index_q;
    rotate         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          rot_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      ST_FETCH: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else begin
          row_literals_d = arr_literals;
          row_phase_d    = arr_phase;
          row_index_d    = 32'(num_qubit - 1) - 32'(rot_cnt_q);
          row_valid_d    = 1'b1;
          state_d        = ST_PRESENT;
        end
      end

      // A transfer always rotates, even when abort arrives in the same cycle.
      ST_PRESENT: begin
        if (row_ready) begin
          rotate      = 1'b1;
          rot_cnt_d   = rot_cnt_q + CNT_ONE;
          row_valid_d = 1'b0;
          if (rot_cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (abort) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (abort) begin
          row_valid_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        rotate    = 1'b1;
        rot_cnt_d = rot_cnt_q + CNT_ONE;
        if (rot_cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rot_cnt_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      row_valid_q    <= 1'b0;
      row_literals_q <= '0;
      row_phase_q    <= 1'b0;
      row_index_q    <= '0;
    end else begin
      state_q        <= state_d;
      rot_cnt_q      <= rot_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      row_valid_q    <= row_valid_d;
      row_literals_q <= row_literals_d;
      row_phase_q    <= row_phase_d;
      row_index_q    <= row_index_d;
    end
  end

  // The rotate enable follows row_ready in PRESENT so the array moves at the transfer edge.
  assign ld_reg             = rotate;
  assign shift_rotate_array = rotate ? ROTATE_DOWN : SHIFT_DOWN;
  assign busy               = busy_q;
  assign done               = done_q;
  assign aborted            = aborted_q;
  assign row_valid          = row_valid_q;
  assign row_literals       = row_literals_q;
  assign row_phase          = row_phase_q;
  assign row_index          = row_index_q;

endmodule

// File: tb/tb_stabilizer_row_reader.sv
// Scoreboard bench for stabilizer_row_reader: a rotating-array model feeds the DUT, the
// stimulus queues the rows and completion status each unload should produce, a monitor checks.
module tb_stabilizer_row_reader;
  import stabilizer_row_reader_pkg::*;

  localparam int NQ       = 4;
  localparam int LW       = 2 * NQ;
  localparam int FULL_LAT = 2 * NQ + 1;

  typedef struct packed {
    logic [LW-1:0] lit;
    logic          ph;
  } row_t;

  typedef struct packed {
    logic [31:0] idx;
    row_t        r;
  } exp_row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, row_ready = 1'b0;
  logic busy, done, aborted, ld_reg, arr_phase, row_phase, row_valid;
  logic [1:0] shift_rotate_array;
  logic [LW-1:0] arr_literals, row_literals;
  logic [31:0] row_index;

  logic s_start = 1'b0, s_ready = 1'b0;
  logic s_busy, s_done, s_aborted, s_ld, s_phase, s_valid;
  logic [1:0] s_shift, s_lit;
  logic [31:0] s_index;

  row_t arr [NQ];
  row_t load_vals [NQ];
  logic load_en = 1'b0;

  exp_row_t exp_q[$];
  logic     exp_ab_q[$];
  int       exp_lat_q[$];

  int   n_checks = 0, n_fail = 0;
  int   tmo_cnt = 0, tmo_seen = 0;
  logic tb_done = 1'b0;

  always #5 clk = ~clk;

  stabilizer_row_reader #(.num_qubit(NQ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .ld_reg(ld_reg),
    .shift_rotate_array(shift_rotate_array),
    .arr_literals(arr_literals), .arr_phase(arr_phase),
    .row_literals(row_literals), .row_phase(row_phase), .row_index(row_index),
    .row_valid(row_valid), .row_ready(row_ready)
  );

  stabilizer_row_reader #(.num_qubit(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .ld_reg(s_ld),
    .shift_rotate_array(s_shift),
    .arr_literals(2'b10), .arr_phase(1'b1),
    .row_literals(s_lit), .row_phase(s_phase), .row_index(s_index),
    .row_valid(s_valid), .row_ready(s_ready)
  );

  // Behavioural row-shift array: bottom row is arr[NQ-1]; rotate-down wraps it to arr[0].
  assign arr_literals = arr[NQ-1].lit;
  assign arr_phase    = arr[NQ-1].ph;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NQ; i++) arr[i] <= load_vals[i];
    end else if (ld_reg && shift_rotate_array == ROTATE_DOWN) begin
      arr[0] <= arr[NQ-1];
      for (int i = 1; i < NQ; i++) arr[i] <= arr[i-1];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end
  endtask

  // Monitor / scoreboard
  int       cyc = 0, start_cyc = 0, rot_seen = 0, lat = 0, s_rows = 0, s_rot = 0;
  logic     in_unload = 1'b0, rst_seen = 1'b0, prev_stall = 1'b0;
  logic [LW-1:0] stall_lit;
  logic [31:0]   stall_idx;
  logic          stall_ph;
  row_t     orig [NQ];
  exp_row_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rst_seen) begin
          chk("reset_ctl", {busy, done, aborted, ld_reg, shift_rotate_array, row_valid, row_phase}, 64'd0);
          chk("reset_payload", {row_literals, row_index}, 64'd0);
          chk("reset_q1", {s_busy, s_done, s_aborted, s_ld, s_shift, s_valid, s_phase, s_lit, s_index}, 64'd0);
        end
        rst_seen   = 1'b1;
        in_unload  = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        exp_ab_q.delete();
        exp_lat_q.delete();
      end else begin
        rst_seen = 1'b0;
        cyc++;
        if (start && !busy && !in_unload) begin
          in_unload = 1'b1;
          start_cyc = cyc;
          rot_seen  = 0;
          for (int i = 0; i < NQ; i++) orig[i] = arr[i];
        end
        if (ld_reg) rot_seen++;
        if (ld_reg || shift_rotate_array != SHIFT_DOWN)
          chk("shift_code", shift_rotate_array, ld_reg ? ROTATE_DOWN : SHIFT_DOWN);
        if (prev_stall) begin
          chk("stall_literals", row_literals, stall_lit);
          chk("stall_index", row_index, stall_idx);
          chk("stall_phase", row_phase, stall_ph);
        end
        prev_stall = row_valid && !row_ready;
        if (prev_stall) begin
          chk("stall_ld_reg", ld_reg, 1'b0);
          stall_lit = row_literals;
          stall_idx = row_index;
          stall_ph  = row_phase;
        end
        if (row_valid && row_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_row: got row_index %0d, required no transfer", row_index);
          end else begin
            e = exp_q.pop_front();
            chk("row_index", row_index, e.idx);
            chk("row_literals", row_literals, e.r.lit);
            chk("row_phase", row_phase, e.r.ph);
          end
        end
        if (done) begin
          if (exp_ab_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, required 0");
          end else begin
            chk("aborted", aborted, exp_ab_q.pop_front());
            lat = exp_lat_q.pop_front();
            if (lat > 0) chk("done_latency", cyc - start_cyc, lat);
          end
          chk("rows_left_at_done", exp_q.size(), 0);
          exp_q.delete();
          chk("rotations", rot_seen, NQ);
          for (int i = 0; i < NQ; i++) chk("array_restored", arr[i], orig[i]);
          chk("busy_at_done", busy, 1'b1);
          in_unload = 1'b0;
        end
        // single-qubit instance
        if (s_start && !s_busy) begin
          s_rows = 0;
          s_rot  = 0;
        end
        if (s_ld) s_rot++;
        if (s_valid && s_ready) begin
          s_rows++;
          chk("q1_row_index", s_index, 32'd0);
          chk("q1_row_payload", {s_lit, s_phase}, 3'b101);
        end
        if (s_done) begin
          chk("q1_rows", s_rows, 1);
          chk("q1_rotations", s_rot, 1);
          chk("q1_aborted", s_aborted, 1'b0);
        end
      end
      if (tmo_cnt != tmo_seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: %0d waits expired, required 0", tmo_cnt - tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (tb_done) begin
        chk("pending_rows", exp_q.size(), 0);
        chk("pending_done", exp_ab_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Stimulus (all tasks start and end one time unit after a rising edge)
  task automatic load_array();
    for (int i = 0; i < NQ; i++) begin
      load_vals[i].lit      = LW'($urandom);
      load_vals[i].lit[1:0] = 2'(i);
      load_vals[i].ph       = 1'($urandom);
    end
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // mode 0: no abort; 1: abort while row k is offered, with row_ready=r; 2: abort in the fetch after k transfers
  task automatic do_unload(input int mode, input int k, input bit r, input int stall_row,
                           input bit rnd, input int dup_at, input int exp_lat);
    int nrows, tcount, iter, stall_left;
    bit ab, just_xfer, issued, stalled, xfer, fin;
    case (mode)
      0:       begin nrows = NQ; ab = 1'b0; end
      1:       begin nrows = r ? k + 1 : k; ab = !(r && k == NQ - 1); end
      default: begin nrows = k; ab = 1'b1; end
    endcase
    for (int j = 0; j < nrows; j++)
      exp_q.push_back('{idx: 32'(NQ - 1 - j), r: load_vals[NQ-1-j]});
    exp_ab_q.push_back(ab);
    exp_lat_q.push_back(exp_lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tcount = 0; iter = 0; stall_left = 0;
    just_xfer = 1'b0; issued = 1'b0; stalled = 1'b0; fin = 1'b0;
    while (!fin && iter < 300) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        abort     = 1'b0;
        start     = 1'b0;
        row_ready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
        if (stall_row >= 0 && !stalled && row_valid && row_index == 32'(stall_row)) begin
          stalled    = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          row_ready = 1'b0;
          stall_left--;
        end
        if (!issued && mode == 1 && row_valid && tcount == k) begin
          abort = 1'b1; row_ready = r; issued = 1'b1;
        end
        if (!issued && mode == 2 && (iter == 0 || just_xfer) && tcount == k) begin
          abort = 1'b1; row_ready = 1'($urandom_range(0, 1)); issued = 1'b1;
        end
        if (iter == dup_at) start = 1'b1;
        xfer = row_valid && row_ready;
        @(posedge clk); #1;
        if (xfer) tcount++;
        just_xfer = xfer;
        iter++;
      end
    end
    if (!fin) tmo_cnt++;
    abort = 1'b0; start = 1'b0; row_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic q1_unload();
    int n;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 50) begin
      s_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!s_done) tmo_cnt++;
    s_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    load_array();
    do_unload(0, 0, 1'b0, -1, 1'b0, -1, FULL_LAT);
    do_unload(0, 0, 1'b0, 2, 1'b0, -1, 0);
    do_unload(1, 1, 1'b0, -1, 1'b0, -1, 0);
    do_unload(1, NQ - 1, 1'b1, -1, 1'b0, -1, 0);
    do_unload(0, 0, 1'b0, -1, 1'b0, 3, FULL_LAT);
    // reset in the middle of an unload, with row_ready held high
    for (int j = 0; j < NQ; j++) exp_q.push_back('{idx: 32'(NQ - 1 - j), r: load_vals[NQ-1-j]});
    exp_ab_q.push_back(1'b0);
    exp_lat_q.push_back(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    row_ready = 1'b0;
    load_array();
    do_unload(0, 0, 1'b0, -1, 1'b0, -1, FULL_LAT);
    repeat (3) q1_unload();
    repeat (24) begin
      int mode;
      if ($urandom_range(0, 3) == 0) load_array();
      mode = $urandom_range(0, 2);
      do_unload(mode, $urandom_range(0, NQ - 1), 1'($urandom_range(0, 1)), -1, 1'b1, -1, 0);
    end
    tb_done = 1'b1;
  end

endmodule
